rob_buffer: RTL and testbench

- Reorder buffer: the responder/storage end of the renaming-to-ROB dispatch interface.
- Accepts up to MACHINE_WIDTH in-order allocations per cycle from renaming and returns their ROB addresses.
- Records out-of-order completions from the commit stage.
- Retires completed entries in program order toward the RAT/ARF. An excepting entry at the head flushes the whole buffer.

---
 rtl/rob_buffer_if.sv | 50 +++++
 rtl/rob_buffer.sv | 170 +++++++++++++++++
 tb/tb_rob_buffer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rob_buffer_if.sv
// rob_buffer_if: dispatch/completion/retire bundle around the reorder buffer.
//   alloc_*   : in-order allocation request from renaming (master drives)
//   alloc_ready, rob_addr_new : acceptance and assigned ROB addresses (slave drives)
//   cmpl_*    : out-of-order completion writes from the commit stage (master drives)
//   retire_*, flush : in-order retirement toward RAT/ARF and flush pulse (slave drives)
interface rob_buffer_if #(
   parameter int unsigned ROB_DEPTH     = 16,
   parameter int unsigned MACHINE_WIDTH = 2,
   parameter int unsigned CMPL_PORTS    = 2,
   parameter int unsigned CREG_W        = 5,
   parameter int unsigned EXC_W         = 8
);
   localparam int unsigned AW = $clog2(ROB_DEPTH);

   logic [MACHINE_WIDTH-1:0]        alloc_valid;
   logic [MACHINE_WIDTH*CREG_W-1:0] alloc_dst;
   logic [MACHINE_WIDTH*32-1:0]     alloc_pcplus8;
   logic [MACHINE_WIDTH*EXC_W-1:0]  alloc_exception;
   logic                            alloc_ready;
   logic [MACHINE_WIDTH*AW-1:0]     rob_addr_new;

   logic [CMPL_PORTS-1:0]           cmpl_valid;
   logic [CMPL_PORTS*AW-1:0]        cmpl_addr;
   logic [CMPL_PORTS*32-1:0]        cmpl_data;
   logic [CMPL_PORTS*EXC_W-1:0]     cmpl_exception;

   logic [MACHINE_WIDTH-1:0]        retire_valid;
   logic [MACHINE_WIDTH*CREG_W-1:0] retire_dst;
   logic [MACHINE_WIDTH*32-1:0]     retire_data;
   logic [MACHINE_WIDTH*32-1:0]     retire_pcplus8;
   logic [EXC_W-1:0]                retire_exception;
   logic [MACHINE_WIDTH*AW-1:0]     retire_rob_addr;
   logic                            flush;

   modport master (
      output alloc_valid, alloc_dst, alloc_pcplus8, alloc_exception,
      output cmpl_valid, cmpl_addr, cmpl_data, cmpl_exception,
      input  alloc_ready, rob_addr_new,
      input  retire_valid, retire_dst, retire_data, retire_pcplus8,
      input  retire_exception, retire_rob_addr, flush
   );

   modport slave (
      input  alloc_valid, alloc_dst, alloc_pcplus8, alloc_exception,
      input  cmpl_valid, cmpl_addr, cmpl_data, cmpl_exception,
      output alloc_ready, rob_addr_new,
      output retire_valid, retire_dst, retire_data, retire_pcplus8,
      output retire_exception, retire_rob_addr, flush
   );
endinterface

// File: rtl/rob_buffer.sv
// rob_buffer: circular reorder buffer.
//   clk, resetn : clock, asynchronous active-low reset
//   bus (slave) : allocation (up to MACHINE_WIDTH/cycle, returns ROB addresses),
//                 completion (CMPL_PORTS writes/cycle), in-order retire of
//                 MACHINE_WIDTH lanes, and a one-cycle flush pulse after an
//                 excepting entry retires.
module rob_buffer #(
   parameter int unsigned ROB_DEPTH     = 16,
   parameter int unsigned MACHINE_WIDTH = 2,
   parameter int unsigned CMPL_PORTS    = 2,
   parameter int unsigned CREG_W        = 5,
   parameter int unsigned EXC_W         = 8
) (
   input  logic             clk,
   input  logic             resetn,
   rob_buffer_if.slave      bus
);
   localparam int unsigned AW = $clog2(ROB_DEPTH);
   localparam int unsigned PW = AW + 1;   // pointer/count width incl. wrap bit

   logic [PW-1:0]     head_q, head_d, tail_q, tail_d, count_q, count_d;
   logic              flush_q, flush_d;
   logic              valid_q [ROB_DEPTH];
   logic              valid_d [ROB_DEPTH];
   logic              done_q  [ROB_DEPTH];
   logic              done_d  [ROB_DEPTH];
   logic [CREG_W-1:0] dst_q   [ROB_DEPTH];
   logic [CREG_W-1:0] dst_d   [ROB_DEPTH];
   logic [31:0]       data_q  [ROB_DEPTH];
   logic [31:0]       data_d  [ROB_DEPTH];
   logic [31:0]       pc_q    [ROB_DEPTH];
   logic [31:0]       pc_d    [ROB_DEPTH];
   logic [EXC_W-1:0]  exc_q   [ROB_DEPTH];
   logic [EXC_W-1:0]  exc_d   [ROB_DEPTH];

   logic [MACHINE_WIDTH-1:0] ret_v;
   logic [AW-1:0]            ret_idx [MACHINE_WIDTH];
   logic [PW-1:0]            ret_n, alloc_n;
   logic                     chain, flush_now, alloc_ready;
   logic [AW-1:0]            cmpl_a, alloc_idx;

   // Ready is judged on registered occupancy only; retires this cycle do not help.
   assign alloc_ready = (PW'(ROB_DEPTH) - count_q) >= PW'(MACHINE_WIDTH);

   // Retire lanes: each lane needs the previous lane retiring and no exception
   // on any lower lane; an excepting entry may only go out on lane 0.
   always_comb begin
      ret_v = '0;
      ret_n = '0;
      chain = 1'b1;
      for (int unsigned k = 0; k < MACHINE_WIDTH; k++) begin
         ret_idx[k] = head_q[AW-1:0] + AW'(k);
         if (chain && valid_q[ret_idx[k]] && done_q[ret_idx[k]] &&
             (k == 0 || exc_q[ret_idx[k]] == '0)) begin
            ret_v[k] = 1'b1;
            ret_n    = ret_n + PW'(1);
         end
         chain = ret_v[k] && (exc_q[ret_idx[k]] == '0);
      end
      flush_now = ret_v[0] && (exc_q[ret_idx[0]] != '0);
   end

   always_comb begin
      bus.alloc_ready      = alloc_ready;
      bus.flush            = flush_q;
      bus.retire_valid     = ret_v;
      bus.retire_exception = ret_v[0] ? exc_q[ret_idx[0]] : '0;
      bus.rob_addr_new     = '0;
      bus.retire_dst       = '0;
      bus.retire_data      = '0;
      bus.retire_pcplus8   = '0;
      bus.retire_rob_addr  = '0;
      for (int unsigned k = 0; k < MACHINE_WIDTH; k++) begin
         bus.rob_addr_new[k*AW +: AW]        = tail_q[AW-1:0] + AW'(k);
         bus.retire_rob_addr[k*AW +: AW]     = ret_idx[k];
         bus.retire_dst[k*CREG_W +: CREG_W]  = dst_q[ret_idx[k]];
         bus.retire_data[k*32 +: 32]         = data_q[ret_idx[k]];
         bus.retire_pcplus8[k*32 +: 32]      = pc_q[ret_idx[k]];
      end
   end

   // Update order: completions (against registered valid), then retire clears,
   // then allocations into free tail slots; an exception flush overrides all.
   always_comb begin
      valid_d   = valid_q;
      done_d    = done_q;
      dst_d     = dst_q;
      data_d    = data_q;
      pc_d      = pc_q;
      exc_d     = exc_q;
      alloc_n   = '0;
      cmpl_a    = '0;
      alloc_idx = '0;

      // Ascending port order so the higher index wins on an address collision.
      for (int unsigned p = 0; p < CMPL_PORTS; p++) begin
         if (bus.cmpl_valid[p]) begin
            cmpl_a = bus.cmpl_addr[p*AW +: AW];
            if (valid_q[cmpl_a]) begin
               data_d[cmpl_a] = bus.cmpl_data[p*32 +: 32];
               exc_d[cmpl_a]  = exc_q[cmpl_a] | bus.cmpl_exception[p*EXC_W +: EXC_W];
               done_d[cmpl_a] = 1'b1;
            end
         end
      end

      for (int unsigned k = 0; k < MACHINE_WIDTH; k++) begin
         if (ret_v[k]) begin
            valid_d[ret_idx[k]] = 1'b0;
            done_d[ret_idx[k]]  = 1'b0;
         end
      end

      for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
         if (alloc_ready && bus.alloc_valid[i]) begin
            alloc_idx            = tail_q[AW-1:0] + AW'(i);
            valid_d[alloc_idx]   = 1'b1;
            done_d[alloc_idx]    = (bus.alloc_exception[i*EXC_W +: EXC_W] != '0);
            dst_d[alloc_idx]     = bus.alloc_dst[i*CREG_W +: CREG_W];
            data_d[alloc_idx]    = '0;
            pc_d[alloc_idx]      = bus.alloc_pcplus8[i*32 +: 32];
            exc_d[alloc_idx]     = bus.alloc_exception[i*EXC_W +: EXC_W];
            alloc_n              = alloc_n + PW'(1);
         end
      end

      head_d  = head_q + ret_n;
      tail_d  = tail_q + alloc_n;
      count_d = count_q + alloc_n - ret_n;
      flush_d = flush_now;

      if (flush_now) begin
         for (int unsigned e = 0; e < ROB_DEPTH; e++) begin
            valid_d[e] = 1'b0;
            done_d[e]  = 1'b0;
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         flush_q <= 1'b0;
         for (int unsigned e = 0; e < ROB_DEPTH; e++) begin
            valid_q[e] <= 1'b0;
            done_q[e]  <= 1'b0;
            dst_q[e]   <= '0;
            data_q[e]  <= '0;
            pc_q[e]    <= '0;
            exc_q[e]   <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         flush_q <= flush_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         dst_q   <= dst_d;
         data_q  <= data_d;
         pc_q    <= pc_d;
         exc_q   <= exc_d;
      end
   end
endmodule

// File: tb/tb_rob_buffer.sv
// tb_rob_buffer: directed vectors for rob_buffer (ROB_DEPTH 16, 2 lanes, 2 completion ports).
module tb_rob_buffer;
   logic clk;
   logic resetn;
   int unsigned n_checks;
   int unsigned n_pass;

   rob_buffer_if #(.ROB_DEPTH(16), .MACHINE_WIDTH(2), .CMPL_PORTS(2),
                   .CREG_W(5), .EXC_W(8)) bus ();

   rob_buffer #(.ROB_DEPTH(16), .MACHINE_WIDTH(2), .CMPL_PORTS(2),
                .CREG_W(5), .EXC_W(8)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // Advance one clock; inputs and checks happen 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.alloc_valid     = '0;
      bus.alloc_dst       = '0;
      bus.alloc_pcplus8   = '0;
      bus.alloc_exception = '0;
      bus.cmpl_valid      = '0;
      bus.cmpl_addr       = '0;
      bus.cmpl_data       = '0;
      bus.cmpl_exception  = '0;
   endtask

   task automatic alloc2(input logic [4:0] d0, input logic [4:0] d1);
      bus.alloc_valid     = 2'b11;
      bus.alloc_dst       = {d1, d0};
      bus.alloc_pcplus8   = {27'd0, d1, 32'd0} | {59'd0, d0};
      bus.alloc_exception = '0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      idle();
      resetn = 1'b0;
      #2;
      // Reset state
      check("rst_ready",   64'(bus.alloc_ready), 64'd1);
      check("rst_rvalid",  64'(bus.retire_valid), 64'd0);
      check("rst_rexc",    64'(bus.retire_exception), 64'd0);
      check("rst_addr0",   64'(bus.rob_addr_new[3:0]), 64'd0);
      check("rst_addr1",   64'(bus.rob_addr_new[7:4]), 64'd1);
      check("rst_flush",   64'(bus.flush), 64'd0);
      resetn = 1'b1;

      // Allocate two, complete out of order, both retire together
      alloc2(5'd3, 5'd4);
      step();
      check("a2_addr0",  64'(bus.rob_addr_new[3:0]), 64'd2);
      check("a2_addr1",  64'(bus.rob_addr_new[7:4]), 64'd3);
      check("a2_count",  64'(dut.count_q), 64'd2);
      check("a2_rvalid", 64'(bus.retire_valid), 64'd0);
      idle();
      bus.cmpl_valid = 2'b01; bus.cmpl_addr = 8'h01; bus.cmpl_data = {32'd0, 32'hBEEF};
      step();
      check("c1_rvalid", 64'(bus.retire_valid), 64'd0);
      bus.cmpl_addr = 8'h00; bus.cmpl_data = {32'd0, 32'h1234};
      step();
      check("r2_rvalid", 64'(bus.retire_valid), 64'd3);
      check("r2_data0",  64'(bus.retire_data[31:0]), 64'h1234);
      check("r2_data1",  64'(bus.retire_data[63:32]), 64'hBEEF);
      check("r2_dst0",   64'(bus.retire_dst[4:0]), 64'd3);
      check("r2_dst1",   64'(bus.retire_dst[9:5]), 64'd4);
      check("r2_pc1",    64'(bus.retire_pcplus8[63:32]), 64'd4);
      check("r2_raddr1", 64'(bus.retire_rob_addr[7:4]), 64'd1);
      check("r2_rexc",   64'(bus.retire_exception), 64'd0);
      idle();
      step();
      check("r2_head",   64'(dut.head_q), 64'd2);
      check("r2_count",  64'(dut.count_q), 64'd0);
      check("r2_after",  64'(bus.retire_valid), 64'd0);

      // Fill to 16 with no completions
      for (int c = 0; c < 8; c++) begin
         check("fill_ready", 64'(bus.alloc_ready), 64'd1);
         alloc2(5'(2 * c), 5'(2 * c + 1));
         step();
      end
      check("full_ready", 64'(bus.alloc_ready), 64'd0);
      check("full_count", 64'(dut.count_q), 64'd16);
      step();   // alloc_valid still 11: must be ignored
      check("full_tail",  64'(dut.tail_q), 64'd18);
      check("full_addr0", 64'(bus.rob_addr_new[3:0]), 64'd2);
      check("full_cnt2",  64'(dut.count_q), 64'd16);
      idle();
      resetn = 1'b0; #1; resetn = 1'b1;

      // Wrap: count 14 at tail 14, retire 2 while allocating 2
      for (int c = 0; c < 7; c++) begin
         alloc2(5'(c), 5'(c + 10));
         step();
      end
      idle();
      bus.cmpl_valid = 2'b11; bus.cmpl_addr = 8'h10;
      bus.cmpl_data  = {32'hA1, 32'hA0};
      step();
      check("w_rvalid",  64'(bus.retire_valid), 64'd3);
      check("w_addr0",   64'(bus.rob_addr_new[3:0]), 64'd14);
      check("w_addr1",   64'(bus.rob_addr_new[7:4]), 64'd15);
      check("w_ready",   64'(bus.alloc_ready), 64'd1);
      alloc2(5'd20, 5'd21);
      // both ports hit entry 2: port 1 must win
      bus.cmpl_valid = 2'b11; bus.cmpl_addr = 8'h22;
      bus.cmpl_data  = {32'h22, 32'h11};
      step();
      check("w_tail",    64'(dut.tail_q), 64'd16);
      check("w_naddr0",  64'(bus.rob_addr_new[3:0]), 64'd0);
      check("w_naddr1",  64'(bus.rob_addr_new[7:4]), 64'd1);
      check("w_count",   64'(dut.count_q), 64'd14);
      check("w_head",    64'(dut.head_q), 64'd2);
      check("col_rv",    64'(bus.retire_valid), 64'd1);
      check("col_data",  64'(bus.retire_data[31:0]), 64'h22);
      idle();
      bus.cmpl_valid = 2'b01; bus.cmpl_addr = 8'h04; bus.cmpl_data = {32'd0, 32'h44};
      step();
      check("e_head",    64'(dut.head_q), 64'd3);
      check("e_rv0",     64'(bus.retire_valid), 64'd0);
      bus.cmpl_addr = 8'h03; bus.cmpl_data = {32'd0, 32'h33};
      bus.cmpl_exception = 16'h000C;
      step();
      // Exception at head: lane 1 held back although entry 4 is done
      check("e_rv",      64'(bus.retire_valid), 64'd1);
      check("e_rexc",    64'(bus.retire_exception), 64'h0C);
      check("e_flush0",  64'(bus.flush), 64'd0);
      idle();
      alloc2(5'd9, 5'd9);   // discarded by the flush
      step();
      check("f_flush",   64'(bus.flush), 64'd1);
      check("f_count",   64'(dut.count_q), 64'd0);
      check("f_ready",   64'(bus.alloc_ready), 64'd1);
      check("f_rv",      64'(bus.retire_valid), 64'd0);
      check("f_addr0",   64'(bus.rob_addr_new[3:0]), 64'd0);
      // Pre-faulted allocation is done immediately
      idle();
      bus.alloc_valid = 2'b01; bus.alloc_dst = 10'd7; bus.alloc_exception = 16'h0005;
      step();
      check("p_flush",   64'(bus.flush), 64'd0);
      check("p_rv",      64'(bus.retire_valid), 64'd1);
      check("p_rexc",    64'(bus.retire_exception), 64'h05);
      idle();
      step();
      check("p_flush1",  64'(bus.flush), 64'd1);
      step();
      check("p_flush2",  64'(bus.flush), 64'd0);

      // Asynchronous reset mid-operation at count 5
      alloc2(5'd1, 5'd2); step();
      alloc2(5'd3, 5'd4); step();
      idle(); bus.alloc_valid = 2'b01; bus.alloc_dst = 10'd5; step();
      check("m_count",   64'(dut.count_q), 64'd5);
      check("m_addr0",   64'(bus.rob_addr_new[3:0]), 64'd5);
      idle();
      bus.cmpl_valid = 2'b01; bus.cmpl_addr = 8'h00; bus.cmpl_data = {32'd0, 32'h55};
      step();
      check("m_rv",      64'(bus.retire_valid), 64'd1);
      idle();
      #2;
      resetn = 1'b0;
      #1;
      check("ar_rv",     64'(bus.retire_valid), 64'd0);
      check("ar_ready",  64'(bus.alloc_ready), 64'd1);
      check("ar_addr0",  64'(bus.rob_addr_new[3:0]), 64'd0);
      check("ar_addr1",  64'(bus.rob_addr_new[7:4]), 64'd1);
      check("ar_count",  64'(dut.count_q), 64'd0);
      check("ar_rexc",   64'(bus.retire_exception), 64'd0);
      check("ar_flush",  64'(bus.flush), 64'd0);
      resetn = 1'b1;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
